// File: rtl/sync_down_cnt.sv
// sync_down_cnt: loadable synchronous down counter (countdown timer).
// Loads a start value, decrements on each enabled clock while running and
// pulses tc for one cycle when the count reaches its terminal value.
// Optional build macro: SYNC_DOWN_CNT_AUTORELOAD_EN
//   defined   -> at terminal count the counter reloads the last load value and
//                keeps running (periodic tc).
//   undefined -> one-shot: the counter stops at 0 and returns to IDLE.
//
// Control semantics: load and en are level-sampled on every rising clk edge;
// there is no handshake. load wins over en in every state. en only has an
// effect while running (busy=1).
module sync_down_cnt #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,        // asynchronous, active-low
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             en,
  output logic [WIDTH-1:0] out,
  output logic             busy,
  output logic             tc,
  output logic             zero,
  output logic             state_dbg   // 1 = RUN, 0 = IDLE
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic             busy_q, busy_d;
  logic             tc_q, tc_d;
  logic [WIDTH-1:0] dec_val;

`ifdef SYNC_DOWN_CNT_AUTORELOAD_EN
  logic [WIDTH-1:0] reload_q, reload_d;
`endif

  // Borrow-chain decrement: bit i toggles when every lower bit is zero.
  always_comb begin
    logic all_zero_below;
    dec_val        = '0;
    all_zero_below = 1'b1;
    for (int i = 0; i < WIDTH; i++) begin
      dec_val[i]     = out_q[i] ^ all_zero_below;
      all_zero_below = all_zero_below & ~out_q[i];
    end
  end

  // Next-state / next-output logic; load has priority over counting.
  always_comb begin
    state_d = state_q;
    out_d   = out_q;
    tc_d    = 1'b0;
`ifdef SYNC_DOWN_CNT_AUTORELOAD_EN
    reload_d = reload_q;
`endif
    if (load) begin
      out_d   = load_val;
      state_d = (load_val != '0) ? RUN : IDLE;
`ifdef SYNC_DOWN_CNT_AUTORELOAD_EN
      reload_d = load_val;
`endif
    end else if (state_q == RUN && en) begin
      if (out_q == WIDTH'(1)) begin
        tc_d = 1'b1;
`ifdef SYNC_DOWN_CNT_AUTORELOAD_EN
        out_d = reload_q;
`else
        out_d   = '0;
        state_d = IDLE;
`endif
      end else if (out_q != '0) begin
        // out==0 never occurs in RUN; the guard keeps it from wrapping.
        out_d = dec_val;
      end
    end
    busy_d = (state_d == RUN);
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      out_q   <= '0;
      busy_q  <= 1'b0;
      tc_q    <= 1'b0;
`ifdef SYNC_DOWN_CNT_AUTORELOAD_EN
      reload_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
      busy_q  <= busy_d;
      tc_q    <= tc_d;
`ifdef SYNC_DOWN_CNT_AUTORELOAD_EN
      reload_q <= reload_d;
`endif
    end
  end

  assign out       = out_q;
  assign busy      = busy_q;
  assign tc        = tc_q;
  assign zero      = (out_q == '0);
  assign state_dbg = (state_q == RUN);

endmodule

// File: tb/tb_sync_down_cnt.sv
// tb_sync_down_cnt: directed plus random stimulus against a behavioural
// countdown model, for a WIDTH=4 and a WIDTH=8 instance sharing clk/rst.
module tb_sync_down_cnt;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  // ---------------- DUT signals ----------------
  logic       load4, en4;
  logic [3:0] lv4, out4;
  logic       busy4, tc4, zero4, st4;

  logic       load8, en8;
  logic [7:0] lv8, out8;
  logic       busy8, tc8, zero8, st8;

  sync_down_cnt #(.WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .load(load4), .load_val(lv4), .en(en4),
    .out(out4), .busy(busy4), .tc(tc4), .zero(zero4), .state_dbg(st4)
  );

  sync_down_cnt #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .load(load8), .load_val(lv8), .en(en8),
    .out(out8), .busy(busy8), .tc(tc8), .zero(zero8), .state_dbg(st8)
  );

  // ---------------- reference model ----------------
  // Countdown described as: remaining count, running flag, tc of this cycle,
  // and the last loaded period.
  typedef struct {
    int remaining;
    bit running;
    bit tc;
    int period;
  } model_t;

  model_t m4, m8;
  int n_cmp = 0;
  int n_err = 0;

  function automatic model_t model_reset();
    model_t m;
    m.remaining = 0;
    m.running   = 0;
    m.tc        = 0;
    m.period    = 0;
    return m;
  endfunction

  function automatic model_t model_step(model_t m, bit ld, int lv, bit en);
    model_t n = m;
    n.tc = 0;
    if (ld) begin
      n.remaining = lv;
      n.period    = lv;
      n.running   = (lv != 0);
    end else if (m.running && en) begin
      if (m.remaining == 1) begin
        n.tc = 1;
`ifdef SYNC_DOWN_CNT_AUTORELOAD_EN
        n.remaining = m.period;
`else
        n.remaining = 0;
        n.running   = 0;
`endif
      end else begin
        n.remaining = m.remaining - 1;
      end
    end
    return n;
  endfunction

  // ---------------- scoreboard ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    check("out4",  32'(out4),  32'(m4.remaining));
    check("busy4", 32'(busy4), 32'(m4.running));
    check("tc4",   32'(tc4),   32'(m4.tc));
    check("zero4", 32'(zero4), 32'(m4.remaining == 0));
    check("st4",   32'(st4),   32'(m4.running));
    check("out8",  32'(out8),  32'(m8.remaining));
    check("busy8", 32'(busy8), 32'(m8.running));
    check("tc8",   32'(tc8),   32'(m8.tc));
    check("zero8", 32'(zero8), 32'(m8.remaining == 0));
  endtask

  // ---------------- driver ----------------
  // One clock: advance the model with the inputs present at the edge, then
  // sample the DUT 1 ns after the edge.
  task automatic tick();
    @(posedge clk);
    if (!rst) begin
      m4 = model_reset();
      m8 = model_reset();
    end else begin
      m4 = model_step(m4, load4, int'(lv4), en4);
      m8 = model_step(m8, load8, int'(lv8), en8);
    end
    #1;
    check_all();
  endtask

  task automatic drive4(input bit ld, input int lv, input bit en);
    load4 = ld;
    lv4   = 4'(lv);
    en4   = en;
  endtask

  task automatic drive8(input bit ld, input int lv, input bit en);
    load8 = ld;
    lv8   = 8'(lv);
    en8   = en;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b0;
    drive4(0, 0, 0);
    drive8(0, 0, 0);
    m4 = model_reset();
    m8 = model_reset();

    // Reset values before any clock edge.
    #2;
    check("rst_out4",  32'(out4),  32'd0);
    check("rst_busy4", 32'(busy4), 32'd0);
    check("rst_tc4",   32'(tc4),   32'd0);
    check("rst_zero4", 32'(zero4), 32'd1);
    tick();
    rst = 1'b1;

    // One-shot: load 3 with en held high.
    drive4(1, 3, 1);
    tick();
    drive4(0, 0, 1);
    repeat (4) tick();

    // Pause, then full range from 15.
    drive4(1, 15, 1);
    tick();
    drive4(0, 0, 1); tick();
    drive4(0, 0, 0); tick();
    drive4(0, 0, 0); tick();
    drive4(0, 0, 1); tick();
    check("pause_out4", 32'(out4), 32'd13);
    repeat (13) tick();
    check("full_tc4", 32'(tc4), 32'd1);
    drive4(0, 0, 0);
    tick();

    // Load priority at out==1 with en high.
    drive4(1, 2, 1); tick();
    drive4(0, 0, 1); tick();
    drive4(1, 6, 1); tick();
    check("prio_out4", 32'(out4), 32'd6);
    check("prio_tc4",  32'(tc4),  32'd0);
    drive4(0, 0, 1);
    repeat (5) tick();
    drive4(1, 0, 1); tick();
    check("prio0_busy4", 32'(busy4), 32'd0);
    drive4(0, 0, 0);

    // Borrow chain on the 8-bit instance.
    drive8(1, 8'h80, 0); tick();
    drive8(0, 0, 1); tick();
    check("borrow_out8", 32'(out8), 32'h7F);
    drive8(0, 0, 0);

    // Asynchronous reset mid-count at out==5.
    drive4(1, 9, 1); tick();
    drive4(0, 0, 1);
    repeat (4) tick();
    drive4(0, 0, 0);
    #3;
    rst = 1'b0;
    #1;
    check("arst_out4",  32'(out4),  32'd0);
    check("arst_busy4", 32'(busy4), 32'd0);
    check("arst_tc4",   32'(tc4),   32'd0);
    tick();
    rst = 1'b1;
    drive4(0, 0, 1);
    drive8(0, 0, 1);
    tick();
    tick();

    // Randomized traffic on both instances.
    for (int i = 0; i < 600; i++) begin
      drive4(($urandom_range(0, 9) == 0), $urandom_range(0, 15), ($urandom_range(0, 3) != 0));
      drive8(($urandom_range(0, 39) == 0), $urandom_range(0, 255), ($urandom_range(0, 3) != 0));
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
